// File: rtl/io_timer_unit.sv
// io_timer_unit: memory-mapped RISC-V machine timer.
// Holds the 64-bit mtime counter and the mtimecmp compare register, each accessed as two
// 32-bit halves, and drives the machine timer interrupt level.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   wrEnable       write strobe
//   wrAddr         0 = mtime.low, 1 = mtime.hi, 2 = mtimecmp.low, 3 = mtimecmp.hi
//   wrData         write data
//   rdEnable       read strobe
//   rdAddr         read target, same encoding as wrAddr
//   rdData         registered read data, held when no read is issued
//   rdValid        rdData valid this cycle
//   timerInterrupt registered level, 1 while mtime >= mtimecmp
//   mtimeOut       current mtime value for the time CSR
module io_timer_unit #(
  parameter int unsigned TICK_DIVIDER = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrEnable,
  input  logic [1:0]  wrAddr,
  input  logic [31:0] wrData,
  input  logic        rdEnable,
  input  logic [1:0]  rdAddr,
  output logic [31:0] rdData,
  output logic        rdValid,
  output logic        timerInterrupt,
  output logic [63:0] mtimeOut
);

  typedef logic [31:0] DataPath;

  typedef union packed {
    logic [63:0] raw;
    struct packed {
      DataPath hi;
      DataPath low;
    } split;
  } TimerRegisterPath;

  localparam logic [15:0] DivLast = 16'(TICK_DIVIDER - 1);

  TimerRegisterPath mtimeQ;
  TimerRegisterPath mtimecmpQ;
  logic [15:0]      divCountQ;

  logic    tick;
  logic    mtimeWrite;
  logic    mtimecmpWrite;
  DataPath rdSel;

  always_comb begin
    tick          = (divCountQ == DivLast);
    mtimeWrite    = wrEnable && !wrAddr[1];
    mtimecmpWrite = wrEnable && wrAddr[1];
    rdSel         = '0;
    unique case (rdAddr)
      2'd0: rdSel = mtimeQ.split.low;
      2'd1: rdSel = mtimeQ.split.hi;
      2'd2: rdSel = mtimecmpQ.split.low;
      2'd3: rdSel = mtimecmpQ.split.hi;
      default: rdSel = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtimeQ.raw     <= '0;
      mtimecmpQ.raw  <= '1;
      divCountQ      <= '0;
      rdData         <= '0;
      rdValid        <= 1'b0;
      timerInterrupt <= 1'b0;
    end else begin
      // An mtime write suppresses this cycle's increment and restarts the divider period.
      if (mtimeWrite) begin
        if (wrAddr[0]) begin
          mtimeQ.split.hi <= wrData;
        end else begin
          mtimeQ.split.low <= wrData;
        end
        divCountQ <= '0;
      end else begin
        if (tick) begin
          mtimeQ.raw <= mtimeQ.raw + 64'd1;
          divCountQ  <= '0;
        end else begin
          divCountQ <= divCountQ + 16'd1;
        end
      end

      if (mtimecmpWrite) begin
        if (wrAddr[0]) begin
          mtimecmpQ.split.hi <= wrData;
        end else begin
          mtimecmpQ.split.low <= wrData;
        end
      end

      // rdSel reflects pre-update register contents, so a same-cycle write is not seen.
      rdValid <= rdEnable;
      if (rdEnable) begin
        rdData <= rdSel;
      end

      timerInterrupt <= (mtimeQ.raw >= mtimecmpQ.raw);
    end
  end

  assign mtimeOut = mtimeQ.raw;

endmodule
